// File: rtl/seq_frame_rx.sv
// Serial frame receiver: aligns on the preamble-detect strobe, deserialises a length
// field and that many MSB-first payload words. Optional parity: SEQ_FRAME_RX_PARITY_EN.
module seq_frame_rx #(
  parameter int DW    = 8,
  parameter int LEN_W = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          serIn,
  input  logic          preDet,
  input  logic          outReady,
  output logic [DW-1:0] dataOut,
  output logic          dataValid,
  output logic          frameDone,
  output logic          busy,
  output logic          overrun,
  output logic          parErr
);
  localparam int CW = $clog2((DW > LEN_W) ? DW : LEN_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
`ifdef SEQ_FRAME_RX_PARITY_EN
    S_PAR,
`endif
    S_DONE
  } state_t;

  state_t           state, state_n;
  logic [CW-1:0]    bit_cnt, bit_n;
  logic [LEN_W-1:0] word_cnt, word_n;
  logic [LEN_W-1:0] len_q;
  logic [DW-2:0]    sh;
  logic [LEN_W-1:0] len_full;
  logic [DW-1:0]    word_full;
  logic             start, ld, word_last;
`ifdef SEQ_FRAME_RX_PARITY_EN
  logic             par_bad;
`endif

  // Full values include the bit on serIn this cycle, so loads happen on the last bit.
  assign len_full  = {len_q[LEN_W-2:0], serIn};
  assign word_full = {sh, serIn};
  assign word_last = (word_cnt + LEN_W'(1)) == len_q;
  assign frameDone = (state == S_DONE);
  assign busy      = (state != S_IDLE);

  always_comb begin
    state_n = state;
    bit_n   = bit_cnt;
    word_n  = word_cnt;
    start   = 1'b0;
    ld      = 1'b0;
`ifdef SEQ_FRAME_RX_PARITY_EN
    par_bad = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (preDet) begin
          start   = 1'b1;
          bit_n   = CW'(1);
          state_n = S_LEN;
        end
      end
      S_LEN: begin
        bit_n = bit_cnt + CW'(1);
        if (bit_cnt == CW'(LEN_W-1)) begin
          bit_n   = '0;
          word_n  = '0;
          state_n = (len_full == '0) ? S_DONE : S_DATA;
        end
      end
      S_DATA: begin
        bit_n = bit_cnt + CW'(1);
        if (bit_cnt == CW'(DW-1)) begin
          ld    = 1'b1;
          bit_n = '0;
`ifdef SEQ_FRAME_RX_PARITY_EN
          state_n = S_PAR;
`else
          word_n = word_cnt + LEN_W'(1);
          if (word_last) state_n = S_DONE;
`endif
        end
      end
`ifdef SEQ_FRAME_RX_PARITY_EN
      S_PAR: begin
        // dataOut holds the word loaded on the previous edge
        par_bad = ^{dataOut, serIn};
        word_n  = word_cnt + LEN_W'(1);
        state_n = word_last ? S_DONE : S_DATA;
      end
`endif
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      bit_cnt  <= '0;
      word_cnt <= '0;
    end else begin
      state    <= state_n;
      bit_cnt  <= bit_n;
      word_cnt <= word_n;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q     <= '0;
      sh        <= '0;
      dataOut   <= '0;
      dataValid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (start || state == S_LEN) len_q <= len_full;
      if (state == S_DATA) sh <= word_full[DW-2:0];
      if (ld) begin
        dataOut   <= word_full;
        dataValid <= 1'b1;
      end else if (outReady) begin
        dataValid <= 1'b0;
      end
      // accept-and-load in the same cycle is a clean handoff, not an overrun
      if (start) overrun <= 1'b0;
      else if (ld && dataValid && !outReady) overrun <= 1'b1;
    end
  end

`ifdef SEQ_FRAME_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         parErr <= 1'b0;
    else if (start)   parErr <= 1'b0;
    else if (par_bad) parErr <= 1'b1;
  end
`else
  assign parErr = 1'b0;
`endif

endmodule

// File: tb/tb_seq_frame_rx.sv
// Bench for seq_frame_rx: zero-length vector table, directed corner frames, and
// random frames checked per cycle against a frame-position reference model.
module tb_seq_frame_rx;
  localparam int DW    = 8;
  localparam int LEN_W = 4;
`ifdef SEQ_FRAME_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic clk = 1'b0, rst = 1'b0, serIn = 1'b0, preDet = 1'b0, outReady = 1'b0;
  logic [DW-1:0] dataOut;
  logic dataValid, frameDone, busy, overrun, parErr;

  seq_frame_rx #(.DW(DW), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .serIn(serIn), .preDet(preDet), .outReady(outReady),
    .dataOut(dataOut), .dataValid(dataValid), .frameDone(frameDone),
    .busy(busy), .overrun(overrun), .parErr(parErr)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: tracks position within the frame, not receiver states.
  logic          m_valid, m_ovr, m_par, m_busy, m_done, m_act;
  logic [DW-1:0] m_data;
  int            m_pos, m_L;
  logic          bits[$];

  function automatic void model_reset();
    m_valid = 0; m_ovr = 0; m_par = 0; m_busy = 0; m_done = 0; m_act = 0;
    m_data = '0; m_pos = 0; m_L = 0;
    bits.delete();
  endfunction

  function automatic int bits_val(input int from, input int n);
    int v = 0;
    for (int i = 0; i < n; i++) v = (v << 1) | int'(bits[from+i]);
    return v;
  endfunction

  function automatic void model_step(input logic s, input logic pd, input logic rdy);
    logic nv, no, np;
    logic [DW-1:0] nd;
    int rel, off, ones;
    nv = m_valid; nd = m_data; no = m_ovr; np = m_par;
    if (m_valid && rdy) nv = 0;
    if (m_done) begin
      m_done = 0; m_busy = 0;
    end else if (!m_act) begin
      if (pd) begin
        m_act = 1; m_busy = 1; m_pos = 0; no = 0; np = 0;
        bits.delete(); bits.push_back(s);
      end
    end else begin
      m_pos++;
      bits.push_back(s);
      if (m_pos == LEN_W-1) m_L = bits_val(0, LEN_W);
      if (m_pos >= LEN_W) begin
        rel = m_pos - LEN_W;
        off = rel % (DW+P);
        if (off == DW-1) begin
          nd = DW'(bits_val(m_pos-DW+1, DW));
          if (m_valid && !rdy) no = 1;
          nv = 1;
        end
        if (P == 1 && off == DW) begin
          ones = 0;
          for (int i = m_pos-DW; i <= m_pos; i++) ones += int'(bits[i]);
          if (ones % 2 == 1) np = 1;
        end
      end
      if (m_pos == LEN_W-1 + m_L*(DW+P)) begin
        m_act = 0; m_done = 1;
      end
    end
    m_valid = nv; m_data = nd; m_ovr = no; m_par = np;
  endfunction

  task automatic check_model();
    chk("dataValid", 32'(dataValid), 32'(m_valid));
    chk("dataOut",   32'(dataOut),   32'(m_data));
    chk("frameDone", 32'(frameDone), 32'(m_done));
    chk("busy",      32'(busy),      32'(m_busy));
    chk("overrun",   32'(overrun),   32'(m_ovr));
    chk("parErr",    32'(parErr),    32'(m_par));
  endtask

  logic [DW-1:0] rxq[$];
  int            done_cnt;
  logic [DW-1:0] fw[16];
  logic          fp[16];

  task automatic cyc(input logic s, input logic pd, input logic rdy);
    serIn = s; preDet = pd; outReady = rdy;
    @(negedge clk);
    check_model();
    if (dataValid && outReady) rxq.push_back(dataOut);
    if (frameDone) done_cnt++;
    model_step(s, pd, rdy);
    @(posedge clk);
    #1;
  endtask

  function automatic logic pick(input int m);
    if (m == 0) return 1'b1;
    if (m == 1) return 1'b0;
    return ($urandom_range(0, 3) != 0);
  endfunction

  // rmode: 0 always ready, 1 never ready, 2 random; spur_at: extra preDet bit index
  task automatic send_frame(input int len, input int rmode, input int spur_at);
    logic q[$];
    for (int i = LEN_W-1; i >= 0; i--) q.push_back(len[i]);
    for (int k = 0; k < len; k++) begin
      for (int b = DW-1; b >= 0; b--) q.push_back(fw[k][b]);
      if (P == 1) q.push_back(fp[k]);
    end
    for (int i = 0; i < q.size(); i++) cyc(q[i], (i == 0) || (i == spur_at), pick(rmode));
    cyc(1'($urandom), 1'b0, pick(rmode));
  endtask

  task automatic set_words(input logic [DW-1:0] a, input logic [DW-1:0] b);
    fw[0] = a; fw[1] = b;
    fp[0] = ^a; fp[1] = ^b;
    rxq.delete(); done_cnt = 0;
  endtask

  typedef struct {
    logic s, pd, rdy, e_busy, e_done, e_valid;
  } vec_t;
  vec_t tbl[6];

  initial begin
    model_reset();
    tbl[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    // reset state
    @(negedge clk);
    chk("rst_valid", 32'(dataValid), 0);
    chk("rst_data",  32'(dataOut),   0);
    chk("rst_busy",  32'(busy),      0);
    chk("rst_done",  32'(frameDone), 0);
    chk("rst_ovr",   32'(overrun),   0);
    chk("rst_par",   32'(parErr),    0);
    @(posedge clk); #1 rst = 1'b1;
    cyc(1'b1, 1'b0, 1'b1);

    // zero-length frame
    for (int i = 0; i < 6; i++) begin
      serIn = tbl[i].s; preDet = tbl[i].pd; outReady = tbl[i].rdy;
      @(negedge clk);
      check_model();
      chk("tbl_busy",  32'(busy),      32'(tbl[i].e_busy));
      chk("tbl_done",  32'(frameDone), 32'(tbl[i].e_done));
      chk("tbl_valid", 32'(dataValid), 32'(tbl[i].e_valid));
      model_step(tbl[i].s, tbl[i].pd, tbl[i].rdy);
      @(posedge clk); #1;
    end

    // len=2 frame, always ready
    set_words(8'hA5, 8'h3C);
    send_frame(2, 0, -1);
    cyc(1'b0, 1'b0, 1'b1);
    chk("f2_count", 32'(rxq.size()), 2);
    if (rxq.size() == 2) begin
      chk("f2_w0", 32'(rxq[0]), 32'h A5);
      chk("f2_w1", 32'(rxq[1]), 32'h 3C);
    end
    chk("f2_done", 32'(done_cnt), 1);
    chk("f2_ovr",  32'(overrun),  0);

    // back-pressure: second word overwrites first
    set_words(8'h11, 8'h22);
    send_frame(2, 1, -1);
    chk("bp_valid", 32'(dataValid), 1);
    chk("bp_data",  32'(dataOut),   32'h22);
    chk("bp_ovr",   32'(overrun),   1);
    chk("bp_taken", 32'(rxq.size()), 0);
    cyc(1'b0, 1'b0, 1'b1);
    chk("bp_clear", 32'(dataValid), 0);
    chk("bp_sticky", 32'(overrun),  1);

    // spurious strobe in the middle of the payload
    set_words(8'h7E, 8'h00);
    send_frame(1, 0, LEN_W + 3);
    cyc(1'b0, 1'b0, 1'b1);
    chk("sp_count", 32'(rxq.size()), 1);
    if (rxq.size() == 1) chk("sp_w0", 32'(rxq[0]), 32'h7E);
    chk("sp_done", 32'(done_cnt), 1);
    chk("sp_busy", 32'(busy), 0);

    // reset three bits into a len=1 payload
    cyc(1'b0, 1'b1, 1'b1); cyc(1'b0, 1'b0, 1'b1); cyc(1'b0, 1'b0, 1'b1); cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1); cyc(1'b1, 1'b0, 1'b1); cyc(1'b1, 1'b0, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("mr_busy",  32'(busy),      0);
    chk("mr_valid", 32'(dataValid), 0);
    chk("mr_data",  32'(dataOut),   0);
    chk("mr_ovr",   32'(overrun),   0);
    model_reset();
    @(posedge clk); #1 rst = 1'b1;
    set_words(8'hC3, 8'h00);
    send_frame(1, 0, -1);
    cyc(1'b0, 1'b0, 1'b1);
    chk("mr_count", 32'(rxq.size()), 1);
    if (rxq.size() == 1) chk("mr_w0", 32'(rxq[0]), 32'hC3);

`ifdef SEQ_FRAME_RX_PARITY_EN
    set_words(8'h0F, 8'h00);
    fp[0] = 1'b1;
    send_frame(1, 0, -1);
    chk("par_err", 32'(parErr), 1);
    if (rxq.size() == 1) chk("par_w0", 32'(rxq[0]), 32'h0F);
    else chk("par_count", 32'(rxq.size()), 1);
    set_words(8'h0F, 8'h00);
    fp[0] = 1'b0;
    send_frame(1, 0, -1);
    chk("par_clr", 32'(parErr), 0);
`endif

    // random frames, first one at maximum length
    for (int f = 0; f < 40; f++) begin
      int len, spur, gap;
      len = (f == 0) ? (1 << LEN_W) - 1 : int'($urandom_range(0, (1 << LEN_W) - 1));
      for (int k = 0; k < 16; k++) begin
        fw[k] = DW'($urandom);
        fp[k] = (^fw[k]) ^ ($urandom_range(0, 3) == 0);
      end
      spur = ($urandom_range(0, 9) < 3) ? int'($urandom_range(1, LEN_W - 1 + len*(DW+P))) : -1;
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) cyc(1'($urandom), 1'b0, pick(2));
      send_frame(len, 2, spur);
    end
    repeat (3) cyc(1'b0, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
